bus_memory: RTL and testbench
=============================

# bus_memory

Single-port 64 x 8 memory that acts as the responder on the CPU memory bus (`adr_bus`, `rd_mem`, `wr_mem`, bidirectional `data_bus`). It sits outside the CPU top level and answers its read and write strobes. After reset it runs a sequential clear sequence before it accepts bus traffic. A side-band loader port lets a host write a program into memory while the CPU is idle.

## Interface

Parameters:
- `AW`, 6: address width; depth is 2^AW words.
- `DW`, 8: data width.
- `CLEAR_VAL`, 8'h00: value written to every word during the clear sequence.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `adr_bus`  in  AW  bus address from the CPU.
- `rd_mem`  in  1  read strobe from the CPU.
- `wr_mem`  in  1  write strobe from the CPU.
- `data_bus`  inout  DW  bus data. Driven by this block only for a valid read; high-Z otherwise.
- `ld_en`  in  1  loader write request.
- `ld_adr`  in  AW  loader address.
- `ld_data`  in  DW  loader write data.
- `ld_ack`  out  1  registered one-cycle pulse; the loader write was committed.
- `ready`  out  1  high once the clear sequence is done.
- `bus_err`  out  1  sticky flag; `rd_mem` and `wr_mem` were asserted together.

## Operation

- FSM has two states: CLEAR and RUN.
- Reset (async) forces:
  - state = CLEAR, `clr_ptr` = 0.
  - `ready` = 0, `ld_ack` = 0, `bus_err` = 0.
  - `data_bus` = Z.
  - Memory contents are not touched asynchronously.
- CLEAR:
  - Each rising edge writes `mem[clr_ptr]` = CLEAR_VAL, then increments `clr_ptr`.
  - On the edge that writes word 2^AW-1, state goes to RUN and `ready` goes to 1.
  - `clr_ptr` does not wrap back into CLEAR.
  - All bus and loader requests are ignored: no write, no `ld_ack`, `data_bus` Z, `bus_err` unaffected.
- RUN, bus read (`rd_mem`=1, `wr_mem`=0):
  - `data_bus` = `mem[adr_bus]` combinationally, in the same cycle the strobe is seen.
  - `data_bus` returns to Z as soon as `rd_mem` falls.
- RUN, bus write (`wr_mem`=1, `rd_mem`=0):
  - `mem[adr_bus]` <= `data_bus` on the rising edge.
  - `data_bus` stays Z.
- RUN, both strobes high:
  - No read drive and no write.
  - `bus_err` <= 1. It stays set until reset.
- RUN, loader (`ld_en`=1):
  - With no bus write in the same cycle: `mem[ld_adr]` <= `ld_data` and `ld_ack` <= 1 for one cycle.
  - With a bus write in the same cycle (including the illegal both-strobes case): the loader write is dropped and `ld_ack` stays 0. The loader must retry.
  - A loader write and a bus read in the same cycle are both allowed. The read returns the pre-edge contents.
- Address arithmetic is unsigned AW-bit. There is no out-of-range case.

## Timing

- Clear takes exactly 2^AW rising edges after `reset` deasserts. With AW=6, `ready` is high after the 64th edge.
- Read latency is 0 cycles (combinational from `adr_bus`/`rd_mem` to `data_bus`), valid within the same clock period. This matches a controller that samples data in the cycle it asserts `rd_mem`.
- Write latency is 1 edge. A read of the same address in the next cycle returns the new value.
- `ld_ack` rises on the edge that commits the write and falls on the following edge unless another write is committed.
- Reset asserted mid-CLEAR or mid-RUN returns to CLEAR immediately and aborts any write in progress. The clear sequence restarts from address 0.
- `data_bus` is never driven while `reset`=1 or `ready`=0.

## Test plan

- Reset, release, count edges: `ready`=0 through edge 63 and 1 at edge 64. Every address then reads 8'h00. `data_bus` is Z with no strobe.
- After `ready`: write 8'hA5 to addr 6'h2A via `wr_mem`. Next cycle, `rd_mem` at 6'h2A shows `data_bus`=8'hA5 in the same cycle. Address 6'h2B still reads 8'h00.
- Loader writes 8'h3C to addr 0 with no bus activity: `ld_ack` pulses for exactly 1 cycle and a bus read at 0 returns 8'h3C. Loader write to 0 concurrent with a bus write of 8'h11 to 0: `ld_ack`=0 and memory[0]=8'h11.
- `rd_mem` and `wr_mem` both high at addr 5 with `data_bus` forced to 8'hFF: `bus_err` goes 1, memory[5] is unchanged, the block does not drive `data_bus`, and `bus_err` stays 1 until reset.
- Pulse `reset` at edge 30 of CLEAR and again after writing 8'h77 in RUN: `ready` drops immediately. After 64 more edges, the previously written address reads 8'h00.
- During CLEAR, assert `rd_mem`, `wr_mem` and `ld_en`: `data_bus` stays Z, `ld_ack`=0, and `bus_err`=0.

Source files
------------

// File: rtl/bus_memory_if.sv
// CPU memory-bus control and side-band loader signals for bus_memory.
// The bidirectional data_bus is a resolved net and stays a module port.
interface bus_memory_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 8
);
  logic [AW-1:0] adr_bus;
  logic          rd_mem;
  logic          wr_mem;
  logic          ld_en;
  logic [AW-1:0] ld_adr;
  logic [DW-1:0] ld_data;
  logic          ld_ack;
  logic          ready;
  logic          bus_err;

  modport master (
    output adr_bus, rd_mem, wr_mem, ld_en, ld_adr, ld_data,
    input  ld_ack, ready, bus_err
  );

  modport slave (
    input  adr_bus, rd_mem, wr_mem, ld_en, ld_adr, ld_data,
    output ld_ack, ready, bus_err
  );
endinterface

// File: rtl/bus_memory.sv
// 2^AW x DW single-port memory responding to CPU bus strobes, with a
// post-reset clear sweep and a loader port that yields to bus writes.
module bus_memory #(
  parameter int unsigned   AW        = 6,
  parameter int unsigned   DW        = 8,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  bus_memory_if.slave  bus,
  inout  wire [DW-1:0] data_bus
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic          ready_q;
  logic          ld_ack_q;
  logic          bus_err_q;
  logic [DW-1:0] mem [2**AW];

  logic          run;
  logic          rd_ok;
  logic          wr_ok;
  logic          both;
  logic          ld_ok;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  // Loader is dropped whenever wr_mem is high, even in the illegal
  // both-strobes case where the bus write itself is also suppressed.
  always_comb begin
    run   = (state == S_RUN);
    rd_ok = run && bus.rd_mem && !bus.wr_mem;
    wr_ok = run && bus.wr_mem && !bus.rd_mem;
    both  = run && bus.rd_mem && bus.wr_mem;
    ld_ok = run && bus.ld_en && !bus.wr_mem;
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = clr_ptr;
    mem_wd = CLEAR_VAL;
    if (state == S_CLEAR) begin
      mem_we = !reset;
    end else if (wr_ok) begin
      mem_we = 1'b1;
      mem_wa = bus.adr_bus;
      mem_wd = data_bus;
    end else if (ld_ok) begin
      mem_we = 1'b1;
      mem_wa = bus.ld_adr;
      mem_wd = bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_CLEAR;
      clr_ptr   <= '0;
      ready_q   <= 1'b0;
      ld_ack_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          ld_ack_q <= 1'b0;
          clr_ptr  <= clr_ptr + 1'b1;
          if (clr_ptr == '1) begin
            state   <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          ld_ack_q <= ld_ok;
          if (both) begin
            bus_err_q <= 1'b1;
          end
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

  assign data_bus    = rd_ok ? mem[bus.adr_bus] : 'z;
  assign bus.ld_ack  = ld_ack_q;
  assign bus.ready   = ready_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_bus_memory.sv
// Directed plus randomized checks of bus_memory against a word-array model.
module tb_bus_memory;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 64;
  localparam logic [7:0]  CLR   = 8'h00;
  // Undriven bus floats to all-ones through the pullup, so non-drive is visible.
  localparam logic [7:0]  FLOAT = 8'hFF;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  bus_memory_if #(.AW(AW), .DW(DW)) bus ();

  wire  [DW-1:0] data_bus;
  logic          tb_drv_en;
  logic [7:0]    tb_drv;
  assign data_bus = tb_drv_en ? tb_drv : 'z;
  pullup (data_bus);

  bus_memory #(.AW(AW), .DW(DW), .CLEAR_VAL(CLR)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .data_bus (data_bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  m_mem [DEPTH];
  logic        m_ready;
  logic        m_err;
  int unsigned m_edges;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rd_mem  = 1'b0;
    bus.wr_mem  = 1'b0;
    bus.adr_bus = '0;
    bus.ld_en   = 1'b0;
    bus.ld_adr  = '0;
    bus.ld_data = '0;
    tb_drv_en   = 1'b0;
    tb_drv      = '0;
  endtask

  // Reset is raised with a read strobe active: the drive must vanish at once.
  task automatic do_reset(input logic [5:0] adr);
    bus.rd_mem  = 1'b1;
    bus.wr_mem  = 1'b0;
    bus.adr_bus = adr;
    tb_drv_en   = 1'b0;
    bus.ld_en   = 1'b0;
    reset       = 1'b1;
    #1;
    check("rst_ready",   {7'd0, bus.ready},   8'h00);
    check("rst_ld_ack",  {7'd0, bus.ld_ack},  8'h00);
    check("rst_bus_err", {7'd0, bus.bus_err}, 8'h00);
    check("rst_data_bus", data_bus, FLOAT);
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_edges = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
  endtask

  // One bus cycle: apply inputs, check the combinational bus, cross the edge,
  // update the model, then check registered outputs.
  task automatic cycle(input logic rd, input logic wr, input logic [5:0] adr,
                       input logic drv_en, input logic [7:0] drv,
                       input logic ld, input logic [5:0] la, input logic [7:0] ld_d);
    logic [7:0] exp_bus;
    logic       exp_ack;
    bus.rd_mem  = rd;
    bus.wr_mem  = wr;
    bus.adr_bus = adr;
    tb_drv_en   = drv_en;
    tb_drv      = drv;
    bus.ld_en   = ld;
    bus.ld_adr  = la;
    bus.ld_data = ld_d;
    #2;
    if (m_ready && rd && !wr) exp_bus = m_mem[adr];
    else if (drv_en)          exp_bus = drv;
    else                      exp_bus = FLOAT;
    check("data_bus", data_bus, exp_bus);
    exp_ack = m_ready && ld && !wr;
    @(posedge clk);
    #1;
    if (!m_ready) begin
      m_edges++;
      if (m_edges == DEPTH) begin
        m_ready = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) m_mem[i] = CLR;
      end
    end else begin
      if (rd && wr)   m_err = 1'b1;
      else if (wr)    m_mem[adr] = drv;
      if (exp_ack)    m_mem[la] = ld_d;
    end
    check("ready",   {7'd0, bus.ready},   {7'd0, m_ready});
    check("ld_ack",  {7'd0, bus.ld_ack},  {7'd0, exp_ack});
    check("bus_err", {7'd0, bus.bus_err}, {7'd0, m_err});
    idle_inputs();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 6'd0, 8'h00);
  endtask

  task automatic rd_at(input logic [5:0] a);
    cycle(1'b1, 1'b0, a, 1'b0, 8'h00, 1'b0, 6'd0, 8'h00);
  endtask

  initial begin
    idle_inputs();
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_edges = 0;
    @(posedge clk);
    #1;
    do_reset(6'd0);

    // Clear sweep: ready low through edge 63, high at edge 64.
    for (int unsigned i = 0; i < DEPTH; i++) idle();
    for (int unsigned a = 0; a < DEPTH; a++) rd_at(6'(a));
    idle();

    // Bus write then same-cycle read on the next cycle.
    cycle(1'b0, 1'b1, 6'h2A, 1'b1, 8'hA5, 1'b0, 6'd0, 8'h00);
    rd_at(6'h2A);
    rd_at(6'h2B);

    // Loader alone, then loader colliding with a bus write.
    cycle(1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 1'b1, 6'd0, 8'h3C);
    idle();
    rd_at(6'd0);
    cycle(1'b0, 1'b1, 6'd0, 1'b1, 8'h11, 1'b1, 6'd0, 8'h3C);
    rd_at(6'd0);

    // Loader write concurrent with a read of the same word: read sees old data.
    cycle(1'b1, 1'b0, 6'd0, 1'b0, 8'h00, 1'b1, 6'd0, 8'h5A);
    rd_at(6'd0);
    cycle(1'b0, 1'b1, 6'd0, 1'b1, 8'h11, 1'b0, 6'd0, 8'h00);

    // Both strobes: no drive, no write, sticky error.
    cycle(1'b1, 1'b1, 6'd5, 1'b1, 8'hFF, 1'b0, 6'd0, 8'h00);
    rd_at(6'd5);
    cycle(1'b1, 1'b1, 6'd0, 1'b1, 8'h00, 1'b1, 6'd9, 8'h42);
    rd_at(6'd0);
    rd_at(6'd9);

    // Randomized traffic; bus_err must stay set throughout.
    for (int i = 0; i < 400; i++) begin
      logic       r, w, l;
      logic [5:0] a, la;
      logic [7:0] d, ld_d;
      int unsigned op;
      op   = $urandom_range(0, 3);
      r    = (op == 1) || (op == 3);
      w    = (op == 2);
      l    = ($urandom_range(0, 2) == 0);
      a    = 6'($urandom_range(0, DEPTH - 1));
      la   = 6'($urandom_range(0, DEPTH - 1));
      d    = 8'($urandom_range(0, 254));
      ld_d = 8'($urandom_range(0, 254));
      cycle(r, w, a, w, d, l, la, ld_d);
    end

    // Reset mid-RUN after a write, then mid-CLEAR at edge 30 with all strobes up.
    cycle(1'b0, 1'b1, 6'h10, 1'b1, 8'h77, 1'b0, 6'd0, 8'h00);
    rd_at(6'h10);
    bus.rd_mem  = 1'b1;
    bus.adr_bus = 6'h10;
    #1;
    check("pre_rst_read", data_bus, 8'h77);
    do_reset(6'h10);
    for (int i = 0; i < 30; i++)
      cycle(1'b1, 1'b1, 6'(i), 1'b0, 8'h00, 1'b1, 6'(i), 8'h66);
    do_reset(6'h10);
    for (int unsigned i = 0; i < DEPTH; i++) idle();
    rd_at(6'h10);
    for (int unsigned a = 0; a < DEPTH; a++) rd_at(6'(a));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
